// File: rtl/line_echo_ctrl.sv
// Line-buffering echo controller: drains the RX FIFO into an editable line
// buffer and, on CR, replays the line to the TX FIFO followed by CR LF.
module line_echo_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Empty_Sig,
  input  logic [7:0] FIFO_Read_Data,
  output logic       Read_Req_Sig,
  input  logic       Full_Sig,
  output logic [7:0] FIFO_Write_Data,
  output logic       Write_Req_Sig,
  output logic       Busy,
  output logic       Overflow_Flag,
  output logic [7:0] Line_Count
);

  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_REQ   = 3'd1;
  localparam logic [2:0] S_RD_CAP   = 3'd2;
  localparam logic [2:0] S_EMIT     = 3'd3;
  localparam logic [2:0] S_EMIT_GAP = 3'd4;
  localparam logic [2:0] S_EMIT_CR  = 3'd5;
  localparam logic [2:0] S_EMIT_LF  = 3'd6;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          ovf_arm_q, ovf_arm_d;
  logic [7:0]    lcnt_q, lcnt_d;
  logic          mem_we;
  logic [CW-1:0] idx_next;

  logic [7:0] line_mem_q [DEPTH];

  assign idx_next = {1'b0, idx_q} + CW'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rd_req_d  = 1'b0;
    wr_req_d  = 1'b0;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    ovf_arm_d = ovf_arm_q;
    lcnt_d    = lcnt_q;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!Empty_Sig) begin
          rd_req_d = 1'b1;
          state_d  = S_RD_REQ;
        end
      end

      S_RD_REQ: state_d = S_RD_CAP;

      S_RD_CAP: begin
        state_d = S_IDLE;
        case (FIFO_Read_Data)
          CH_CR: begin
            busy_d  = 1'b1;
            idx_d   = '0;
            state_d = (cnt_q != '0) ? S_EMIT : S_EMIT_CR;
          end
          CH_BS: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          CH_LF: ;
          default: begin
            if (cnt_q < DEPTH_C) begin
              mem_we = 1'b1;
              cnt_d  = cnt_q + CW'(1);
              // First stored byte after an emission retires the old overflow
              if (ovf_arm_q) begin
                ovf_d     = 1'b0;
                ovf_arm_d = 1'b0;
              end
            end else begin
              ovf_d = 1'b1;
            end
          end
        endcase
      end

      S_EMIT: begin
        if (!Full_Sig) begin
          wr_req_d = 1'b1;
          wdata_d  = line_mem_q[idx_q];
          state_d  = S_EMIT_GAP;
        end
      end

      S_EMIT_GAP: begin
        idx_d   = idx_q + AW'(1);
        state_d = (idx_next == cnt_q) ? S_EMIT_CR : S_EMIT;
      end

      S_EMIT_CR: begin
        if (!Full_Sig) begin
          wr_req_d = 1'b1;
          wdata_d  = CH_CR;
          state_d  = S_EMIT_LF;
        end
      end

      // Wait out the CR pulse so every write is followed by an idle cycle
      S_EMIT_LF: begin
        if (!Full_Sig && !wr_req_q) begin
          wr_req_d  = 1'b1;
          wdata_d   = CH_LF;
          cnt_d     = '0;
          busy_d    = 1'b0;
          lcnt_d    = lcnt_q + 8'd1;
          ovf_arm_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      wdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_arm_q <= 1'b0;
      lcnt_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      ovf_arm_q <= ovf_arm_d;
      lcnt_q    <= lcnt_d;
    end
  end

  // Line storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      line_mem_q[cnt_q[AW-1:0]] <= FIFO_Read_Data;
    end
  end

  assign Read_Req_Sig    = rd_req_q;
  assign Write_Req_Sig   = wr_req_q;
  assign FIFO_Write_Data = wdata_q;
  assign Busy            = busy_q;
  assign Overflow_Flag   = ovf_q;
  assign Line_Count      = lcnt_q;

endmodule
